sample_collector: RTL and testbench

- Downstream consumer of the per-pin sample outputs.
- Scans channels round-robin by driving output_sample/channel_select, and receives the OR-combined sample_data bus from all pin controllers.
- Pushes only new samples into a FIFO. Deduplicates using the 16-bit sample count in bits [31:16] of each sample word.
- The host drains the FIFO over the 16-bit command bus.

---
 rtl/sample_collector_pkg.sv | 16 +
 rtl/sample_fifo.sv | 44 ++++
 rtl/sample_collector.sv | 132 +++++++++++++
 tb/tb_sample_collector.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_collector_pkg.sv
// sample_collector_pkg: shared register map, sample-word field offsets and FSM encoding
// for the sample collector.
package sample_collector_pkg;
    localparam logic [7:0] REG_CMD     = 8'd0;
    localparam logic [7:0] REG_STATUS  = 8'd1;
    localparam logic [7:0] REG_DATA_LO = 8'd2;
    localparam logic [7:0] REG_DATA_HI = 8'd3;
    localparam logic [7:0] REG_MASK    = 8'd4;
    localparam int CMD_CLEAR = 0;
    localparam int CNT_MSB = 31;
    localparam int CNT_LSB = 16;
    localparam int POS_MSB = 15;
    localparam int POS_LSB = 1;
    localparam int BIT     = 0;
    typedef enum logic [1:0] {IDLE, REQ, CAPTURE, NEXT} state_t;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous word FIFO; a pop frees a slot for a push in the same cycle,
// a pop of an empty FIFO is ignored, and clear wins over both.
module sample_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/sample_collector.sv
// sample_collector: round-robin poller of pin controllers that queues only new samples for the host.
// Optional channel mask register enabled by SAMPLE_COLLECTOR_CHANNEL_MASK_EN.
module sample_collector #(
    parameter logic [7:0] POSITION     = 8'hF0,
    parameter int         NUM_CHANNELS = 8,
    parameter int         FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] addr,
    input  logic        data_wr,
    input  logic        data_rd,
    input  logic [31:0] data_in,
    output logic [15:0] data_out,
    input  logic        scan_enable,
    output logic        output_sample,
    output logic [7:0]  channel_select,
    input  logic [31:0] sample_data,
    output logic        sample_available,
    output logic        overflow
);
    import sample_collector_pkg::*;
    localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    state_t state, state_nx;
    logic [CW-1:0] ch, ch_nx, ch_above, ch_low;
    logic has_above, any, go;
    logic [15:0] last_cnt [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] mask;
    logic wr, rd, clear, pop, want, push_ok, full, empty;
    logic [31:0] head;
    logic [FW-1:0] count;
    logic [4:0] cnt5;
    logic [15:0] rd_val, mask_rd;

`ifdef SAMPLE_COLLECTOR_CHANNEL_MASK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) mask <= '1;
        else if (wr && addr[7:0] == REG_MASK) mask <= NUM_CHANNELS'(data_in);
    end
    assign mask_rd = 16'(mask);
`else
    assign mask    = '1;
    assign mask_rd = '0;
`endif

    assign wr      = enable & data_wr & (addr[15:8] == POSITION);
    assign rd      = enable & data_rd & (addr[15:8] == POSITION);
    assign clear   = wr && addr[7:0] == REG_CMD && data_in[CMD_CLEAR];
    assign pop     = rd && addr[7:0] == REG_DATA_HI;
    assign want    = state == CAPTURE && sample_data != '0 && sample_data[CNT_MSB:CNT_LSB] != last_cnt[ch];
    assign push_ok = ~full | (pop & ~empty);
    assign any     = |mask;
    assign go      = scan_enable & any;
    assign cnt5    = count > FW'(31) ? 5'd31 : 5'(count);
    assign sample_available = ~empty;

    // Next enabled channel after ch, wrapping; stays on ch when nothing else is enabled.
    always_comb begin
        has_above = 1'b0;
        ch_above  = ch;
        ch_low    = ch;
        for (int j = NUM_CHANNELS - 1; j >= 0; j--)
            if (mask[j]) begin
                ch_low = CW'(j);
                if (j > int'(ch)) begin
                    ch_above  = CW'(j);
                    has_above = 1'b1;
                end
            end
        ch_nx = has_above ? ch_above : ch_low;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= clear ? IDLE : state_nx;
    end

    always_comb begin
        state_nx = state == IDLE    ? (go ? REQ : IDLE) :
                   state == REQ     ? CAPTURE :
                   state == CAPTURE ? NEXT :
                                      (go ? REQ : IDLE);
    end

    always_comb begin
        output_sample  = state == REQ;
        channel_select = 8'(ch);
    end

    always_comb begin
        rd_val = addr[7:0] == REG_STATUS  ? {overflow, 10'b0, cnt5} :
                 addr[7:0] == REG_DATA_LO ? (empty ? 16'h0 : head[15:0]) :
                 addr[7:0] == REG_DATA_HI ? (empty ? 16'h0 : head[31:16]) :
                 addr[7:0] == REG_MASK    ? mask_rd : 16'h0;
    end

    // A full FIFO leaves last_cnt alone so the dropped sample is retried next sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch       <= '0;
            overflow <= 1'b0;
            data_out <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) last_cnt[i] <= '0;
        end else begin
            data_out <= rd ? rd_val : 16'h0;
            if (clear) begin
                ch       <= '0;
                overflow <= 1'b0;
                for (int i = 0; i < NUM_CHANNELS; i++) last_cnt[i] <= '0;
            end else begin
                if (state == NEXT || (state == IDLE && go && !mask[ch])) ch <= ch_nx;
                if (want && push_ok) last_cnt[ch] <= sample_data[CNT_MSB:CNT_LSB];
                if (want && !push_ok) overflow <= 1'b1;
            end
        end
    end

    sample_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (want),
        .pop   (pop),
        .din   (sample_data),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
endmodule

// File: tb/tb_sample_collector.sv
// tb_sample_collector: directed and randomized bench for sample_collector with a queue-based
// reference model and a pin-controller model that answers one cycle after each request.
module tb_sample_collector;
    logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, data_wr = 1'b0, data_rd = 1'b0;
    logic        scan_enable = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [31:0] data_in = 32'h0;
    logic [15:0] data_out;
    logic        output_sample, sample_available, overflow;
    logic [7:0]  channel_select;
    logic [31:0] sample_data;
    int vectors = 0, errors = 0;
    logic [31:0] word [8];
`ifdef SAMPLE_COLLECTOR_CHANNEL_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    sample_collector dut (
        .clk(clk), .reset(reset), .enable(enable), .addr(addr), .data_wr(data_wr),
        .data_rd(data_rd), .data_in(data_in), .data_out(data_out), .scan_enable(scan_enable),
        .output_sample(output_sample), .channel_select(channel_select), .sample_data(sample_data),
        .sample_available(sample_available), .overflow(overflow)
    );

    // Pin controllers answer the request one cycle later; idle controllers drive 0.
    always @(posedge clk) sample_data <= output_sample ? word[channel_select] : 32'h0;

    // Reference model: queue of accepted words, last count per channel, sticky drop flag.
    logic [31:0] q [$];
    logic [15:0] m_last [8];
    logic        m_ovf, cap_pend, m_rd, m_wr;
    logic [7:0]  m_mask, cap_ch, m_a;
    logic [15:0] exp_rd;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            foreach (m_last[i]) m_last[i] = 16'h0;
            m_ovf = 1'b0; m_mask = 8'hFF; cap_pend = 1'b0; exp_rd = 16'h0;
        end else begin
            m_a  = addr[7:0];
            m_rd = enable && data_rd && addr[15:8] == 8'hF0;
            m_wr = enable && data_wr && addr[15:8] == 8'hF0;
            exp_rd = 16'h0;
            if (m_rd)
                case (m_a)
                    8'd1: exp_rd = {m_ovf, 10'b0, 5'(q.size())};
                    8'd2: exp_rd = q.size() > 0 ? q[0][15:0] : 16'h0;
                    8'd3: exp_rd = q.size() > 0 ? q[0][31:16] : 16'h0;
                    8'd4: exp_rd = MASK_EN ? {8'h0, m_mask} : 16'h0;
                    default: exp_rd = 16'h0;
                endcase
            if (m_wr && m_a == 8'd0 && data_in[0]) begin
                q.delete();
                foreach (m_last[i]) m_last[i] = 16'h0;
                m_ovf = 1'b0; cap_pend = 1'b0;
            end else begin
                if (m_rd && m_a == 8'd3 && q.size() > 0) void'(q.pop_front());
                if (MASK_EN && m_wr && m_a == 8'd4) m_mask = data_in[7:0];
                if (cap_pend && sample_data != 32'h0 && sample_data[31:16] != m_last[cap_ch]) begin
                    if (q.size() < 16) begin
                        q.push_back(sample_data);
                        m_last[cap_ch] = sample_data[31:16];
                    end else m_ovf = 1'b1;
                end
                cap_pend = output_sample;
                cap_ch   = channel_select;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        enable = 1'b1; data_wr = 1'b1; addr = {8'hF0, a}; data_in = d;
        @(negedge clk);
        enable = 1'b0; data_wr = 1'b0; data_in = 32'h0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [15:0] v);
        @(negedge clk);
        enable = 1'b1; data_rd = 1'b1; addr = {8'hF0, a};
        @(negedge clk);
        enable = 1'b0; data_rd = 1'b0;
        v = data_out;
        chk($sformatf("rd_model_a%0d", a), data_out, exp_rd);
    endtask

    task automatic wait_req(input logic [7:0] c);
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (output_sample && channel_select == c) break;
        end
        chk($sformatf("req_seen_ch%0d", c), 32'(n < 200), 1);
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_avail"}, sample_available, q.size() != 0);
        chk({tag, "_ovf"}, overflow, m_ovf);
    endtask

    logic [15:0] v;
    int pulses, r, c;
    logic seen1;
    initial begin
        foreach (word[i]) word[i] = 32'h0;
        tick(3);
        chk("rst_req", output_sample, 0);
        chk("rst_sel", channel_select, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_avail", sample_available, 0);
        reset = 1'b0;
        // single new sample
        word[2] = 32'h0001_0005;
        scan_enable = 1'b1;
        tick(30);
        bus_read(8'd1, v); chk("t1_status", v, 16'h0001);
        bus_read(8'd2, v); chk("t1_lo", v, 16'h0005);
        bus_read(8'd3, v); chk("t1_hi", v, 16'h0001);
        bus_read(8'd1, v); chk("t1_status_after", v, 16'h0000);
        // duplicate suppression
        word[2] = 32'h0;
        word[3] = 32'h0007_0007;
        tick(5 * 24);
        bus_read(8'd1, v); chk("t2_dup_status", v, 16'h0001);
        word[3] = 32'h0008_0007;
        tick(30);
        bus_read(8'd1, v); chk("t2_new_status", v, 16'h0002);
        bus_read(8'd3, v); chk("t2_hi0", v, 16'h0007);
        bus_read(8'd3, v); chk("t2_hi1", v, 16'h0008);
        chk_flags("t2");
        // overflow with stalled host
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) word[i] = {16'(16 + 8 * k + i), 16'($urandom)};
            tick(25);
        end
        chk("t4_ovf", overflow, 1);
        bus_read(8'd1, v); chk("t4_status_full", v, 16'h8010);
        bus_read(8'd3, v);
        tick(30);
        bus_read(8'd1, v); chk("t4_status_refill", v, 16'h8010);
        // full FIFO with push and pop in the same cycle
        scan_enable = 1'b0;
        tick(5);
        bus_write(8'd0, 32'h1);
        for (int i = 0; i < 8; i++) word[i] = {16'h0100 + 16'(i), 16'($urandom)};
        scan_enable = 1'b1;
        wait_req(8'd7); tick(2);
        for (int i = 0; i < 8; i++) word[i] = {16'h0200 + 16'(i), 16'($urandom)};
        wait_req(8'd7); tick(2);
        bus_read(8'd1, v); chk("t5_status_full", v, 16'h0010);
        word[3] = {16'h0300, 16'($urandom)};
        wait_req(8'd3);
        bus_read(8'd3, v); chk("t5_pop_hi", v, 16'h0100);
        tick(2);
        bus_read(8'd1, v); chk("t5_status_after", v, 16'h0010);
        chk("t5_no_ovf", overflow, 0);
        // asynchronous reset during CAPTURE
        wait_req(8'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_req", output_sample, 0);
        chk("t6_avail", sample_available, 0);
        chk("t6_ovf", overflow, 0);
        @(negedge clk);
        reset = 1'b0;
        tick(30);
        bus_read(8'd1, v); chk("t6_status_refill", v, 16'h0008);
        bus_write(8'd0, 32'h1);
        tick(30);
        bus_read(8'd1, v); chk("t6_status_clear", v, 16'h0008);
        // no scanning while scan_enable is low
        scan_enable = 1'b0;
        tick(4);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (output_sample) pulses++;
        end
        chk("t7_no_scan", pulses, 0);
        // randomized traffic against the model
        scan_enable = 1'b1;
        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
                c = $urandom_range(0, 7);
                word[c] = (r == 0) ? 32'h0 : {16'($urandom_range(1, 4)), 16'($urandom)};
                tick(1);
            end else if (r < 7) bus_read(r < 5 ? 8'd3 : 8'($urandom_range(1, 5)), v);
            else if (r == 9 && $urandom_range(0, 3) == 0) bus_write(8'd0, 32'h1);
            else tick($urandom_range(1, 6));
            if ($urandom_range(0, 15) == 0) scan_enable = ~scan_enable;
            chk_flags("rnd");
        end
        scan_enable = 1'b1;
        // channel mask
`ifdef SAMPLE_COLLECTOR_CHANNEL_MASK_EN
        bus_write(8'd4, 32'h5);
        bus_read(8'd4, v); chk("t9_mask_rd", v, 16'h0005);
        bus_write(8'd0, 32'h1);
        pulses = 0;
        repeat (60) begin
            @(negedge clk);
            if (output_sample) begin
                pulses++;
                chk("t9_mask_sel", 32'(channel_select == 8'd0 || channel_select == 8'd2), 1);
            end
        end
        chk("t9_mask_pulses", 32'(pulses >= 15), 1);
        bus_write(8'd4, 32'h0);
        tick(4);
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (output_sample) pulses++;
        end
        chk("t9_mask_zero", pulses, 0);
`else
        bus_write(8'd4, 32'h5);
        bus_read(8'd4, v); chk("t9_mask_rd", v, 16'h0000);
        seen1 = 1'b0;
        repeat (48) begin
            @(negedge clk);
            if (output_sample && channel_select == 8'd1) seen1 = 1'b1;
        end
        chk("t9_all_channels", seen1, 1);
`endif
        chk_flags("end");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
